// File: rtl/noc_ni_port.sv
// NoC network-interface port: credit-governed TX path from the GPU to the router,
// destination-filtered RX path from the router to the GPU, credit return and statistics.
module noc_ni_port #(
    parameter logic [5:0] NODE_ID  = 6'd21,
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4,
    parameter int         CREDITS  = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [15:0] gpu_tx_data,
    input  logic        gpu_tx_valid,
    output logic        gpu_tx_ready,
    output logic [15:0] gpu_rx_data,
    output logic        gpu_rx_valid,
    input  logic        gpu_rx_ready,
    output logic [15:0] link_out_flit,
    output logic        link_out_valid,
    input  logic        link_out_credit,
    input  logic [15:0] link_in_flit,
    input  logic        link_in_valid,
    output logic [1:0]  link_in_credit,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [15:0] drop_count,
    output logic        credit_err,
    output logic        rx_ovf_err
);

    localparam int         TX_AW    = $clog2(TX_DEPTH);
    localparam int         RX_AW    = $clog2(RX_DEPTH);
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    genvar gi;

    // ---------------- TX path ----------------
    logic [TX_AW:0]             tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TX_DEPTH-1:0][15:0]  tx_mem;
    logic                       tx_empty, tx_full, tx_push, tx_send;
    logic [15:0]                tx_head;
    logic [3:0]                 credit_cnt_reg, credit_cnt_next;
    logic                       credit_over;
    logic                       link_out_valid_reg;
    logic [15:0]                link_out_flit_reg;

    assign tx_empty     = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full      = (tx_wr_ptr_reg[TX_AW] != tx_rd_ptr_reg[TX_AW]) &&
                          (tx_wr_ptr_reg[TX_AW-1:0] == tx_rd_ptr_reg[TX_AW-1:0]);
    assign gpu_tx_ready = !tx_full && !ARESET;
    assign tx_push      = gpu_tx_valid && gpu_tx_ready;
    // An empty FIFO forwards the incoming flit directly so injection costs one cycle.
    assign tx_send      = (!tx_empty || tx_push) && (credit_cnt_reg != 4'd0);
    assign tx_head      = tx_empty ? gpu_tx_data : tx_mem[tx_rd_ptr_reg[TX_AW-1:0]];

    generate
        for (gi = 0; gi < TX_DEPTH; gi++) begin : g_tx_entry
            logic [15:0] entry_reg;
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET)
                    entry_reg <= '0;
                else if (tx_push && tx_wr_ptr_reg[TX_AW-1:0] == TX_AW'(gi))
                    entry_reg <= gpu_tx_data;
            end
            assign tx_mem[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        credit_cnt_next = credit_cnt_reg;
        credit_over     = link_out_credit && (credit_cnt_reg == CRED_MAX) && !tx_send;
        case ({tx_send, link_out_credit && !credit_over})
            2'b10:   credit_cnt_next = credit_cnt_reg - 4'd1;
            2'b01:   credit_cnt_next = credit_cnt_reg + 4'd1;
            default: credit_cnt_next = credit_cnt_reg;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tx_wr_ptr_reg      <= '0;
            tx_rd_ptr_reg      <= '0;
            credit_cnt_reg     <= CRED_MAX;
            link_out_valid_reg <= 1'b0;
            link_out_flit_reg  <= '0;
            tx_count           <= '0;
            credit_err         <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + {{TX_AW{1'b0}}, 1'b1};
            if (tx_send) begin
                tx_rd_ptr_reg     <= tx_rd_ptr_reg + {{TX_AW{1'b0}}, 1'b1};
                link_out_flit_reg <= tx_head;
                tx_count          <= sat_inc(tx_count);
            end
            link_out_valid_reg <= tx_send;
            credit_cnt_reg     <= credit_cnt_next;
            if (credit_over)
                credit_err <= 1'b1;
        end
    end

    assign link_out_valid = link_out_valid_reg;
    assign link_out_flit  = link_out_flit_reg;

    // ---------------- RX path ----------------
    logic [RX_AW:0]             rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RX_DEPTH-1:0][15:0]  rx_mem;
    logic                       rx_empty, rx_full, rx_dest_ok, rx_accept, rx_drop, rx_pop;
    logic [1:0]                 link_in_credit_reg;

    assign rx_empty     = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full      = (rx_wr_ptr_reg[RX_AW] != rx_rd_ptr_reg[RX_AW]) &&
                          (rx_wr_ptr_reg[RX_AW-1:0] == rx_rd_ptr_reg[RX_AW-1:0]);
    assign rx_dest_ok   = (link_in_flit[15:10] == NODE_ID);
    // Fullness is judged before any same-cycle pop, so a full FIFO drops even while draining.
    assign rx_accept    = link_in_valid && rx_dest_ok && !rx_full;
    assign rx_drop      = link_in_valid && !rx_accept;
    assign gpu_rx_valid = !rx_empty;
    assign rx_pop       = gpu_rx_valid && gpu_rx_ready;
    assign gpu_rx_data  = rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];

    generate
        for (gi = 0; gi < RX_DEPTH; gi++) begin : g_rx_entry
            logic [15:0] entry_reg;
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET)
                    entry_reg <= '0;
                else if (rx_accept && rx_wr_ptr_reg[RX_AW-1:0] == RX_AW'(gi))
                    entry_reg <= link_in_flit;
            end
            assign rx_mem[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rx_wr_ptr_reg      <= '0;
            rx_rd_ptr_reg      <= '0;
            link_in_credit_reg <= '0;
            rx_count           <= '0;
            drop_count         <= '0;
            rx_ovf_err         <= 1'b0;
        end else begin
            if (rx_accept)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + {{RX_AW{1'b0}}, 1'b1};
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + {{RX_AW{1'b0}}, 1'b1};
                rx_count      <= sat_inc(rx_count);
            end
            if (rx_drop)
                drop_count <= sat_inc(drop_count);
            if (link_in_valid && rx_dest_ok && rx_full)
                rx_ovf_err <= 1'b1;
            link_in_credit_reg <= {1'b0, rx_pop} + {1'b0, rx_drop};
        end
    end

    assign link_in_credit = link_in_credit_reg;

endmodule

// File: tb/tb_noc_ni_port.sv
// Self-checking bench for noc_ni_port: directed scenarios plus random traffic
// compared against a queue-based transaction model of the port.
module tb_noc_ni_port;

    localparam int         TX_DEPTH = 4;
    localparam int         RX_DEPTH = 4;
    localparam int         CREDITS  = 4;
    localparam logic [5:0] NODE_ID  = 6'd21;

    logic        ACLK, ARESET;
    logic [15:0] gpu_tx_data, gpu_rx_data, link_out_flit, link_in_flit;
    logic        gpu_tx_valid, gpu_tx_ready, gpu_rx_valid, gpu_rx_ready;
    logic        link_out_valid, link_out_credit, link_in_valid;
    logic [1:0]  link_in_credit;
    logic [15:0] tx_count, rx_count, drop_count;
    logic        credit_err, rx_ovf_err;

    noc_ni_port #(.NODE_ID(NODE_ID), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .CREDITS(CREDITS)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .gpu_tx_data(gpu_tx_data), .gpu_tx_valid(gpu_tx_valid), .gpu_tx_ready(gpu_tx_ready),
        .gpu_rx_data(gpu_rx_data), .gpu_rx_valid(gpu_rx_valid), .gpu_rx_ready(gpu_rx_ready),
        .link_out_flit(link_out_flit), .link_out_valid(link_out_valid), .link_out_credit(link_out_credit),
        .link_in_flit(link_in_flit), .link_in_valid(link_in_valid), .link_in_credit(link_in_credit),
        .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count),
        .credit_err(credit_err), .rx_ovf_err(rx_ovf_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    logic [15:0] m_tx_q[$];
    logic [15:0] m_rx_q[$];
    int          m_credits, m_tx_cnt, m_rx_cnt, m_drop_cnt, m_in_credit;
    bit          m_cerr, m_oerr, m_out_valid;
    logic [15:0] m_out_flit;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_tx_q.delete();
        m_rx_q.delete();
        m_credits   = CREDITS;
        m_tx_cnt    = 0;
        m_rx_cnt    = 0;
        m_drop_cnt  = 0;
        m_in_credit = 0;
        m_cerr      = 0;
        m_oerr      = 0;
        m_out_valid = 0;
        m_out_flit  = '0;
    endtask

    task automatic model_update();
        bit sent, pop, accept, drop, mine;
        int c0;
        if (gpu_tx_valid && m_tx_q.size() < TX_DEPTH)
            m_tx_q.push_back(gpu_tx_data);
        c0   = m_credits;
        sent = (m_tx_q.size() > 0) && (c0 > 0);
        if (sent) begin
            m_out_flit = m_tx_q.pop_front();
            m_tx_cnt   = sat(m_tx_cnt + 1);
        end
        m_out_valid = sent;
        m_credits   = c0 - int'(sent);
        if (link_out_credit) begin
            if (c0 == CREDITS && !sent) m_cerr = 1;
            else                        m_credits++;
        end
        mine   = link_in_valid && (link_in_flit[15:10] == NODE_ID);
        pop    = (m_rx_q.size() > 0) && gpu_rx_ready;
        accept = mine && (m_rx_q.size() < RX_DEPTH);
        drop   = link_in_valid && !accept;
        if (mine && !accept) m_oerr = 1;
        if (pop) begin
            void'(m_rx_q.pop_front());
            m_rx_cnt = sat(m_rx_cnt + 1);
        end
        if (accept) m_rx_q.push_back(link_in_flit);
        if (drop)   m_drop_cnt = sat(m_drop_cnt + 1);
        m_in_credit = int'(pop) + int'(drop);
    endtask

    task automatic clock_step();
        @(posedge ACLK);
        if (ARESET) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        gpu_tx_valid    = 1'b0;
        gpu_tx_data     = '0;
        gpu_rx_ready    = 1'b0;
        link_out_credit = 1'b0;
        link_in_valid   = 1'b0;
        link_in_flit    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ARESET = 1'b1;
        clock_step();
        clock_step();
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({gpu_tx_ready, gpu_rx_data, gpu_rx_valid, link_out_flit, link_out_valid, link_in_credit,
             tx_count, rx_count, drop_count, credit_err, rx_ovf_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got tx_rdy=%b rx_v=%b out_v=%b cnts=%h/%h/%h required all 0",
                     gpu_tx_ready, gpu_rx_valid, link_out_valid, tx_count, rx_count, drop_count);
        end
        clock_step();
        ARESET = 1'b0;
        clock_step();
        checks++;
        if (gpu_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready: got %b required 1", gpu_tx_ready);
        end
    endtask

    task automatic test_single_inject();
        gpu_tx_data  = 16'h5923;
        gpu_tx_valid = 1'b1;
        clock_step();
        gpu_tx_valid = 1'b0;
        checks++;
        if (link_out_valid !== 1'b1 || link_out_flit !== 16'h5923 || tx_count !== 16'd1) begin
            failures++;
            $display("FAIL inject_first: got v=%b flit=%h cnt=%0d required v=1 flit=5923 cnt=1",
                     link_out_valid, link_out_flit, tx_count);
        end
        clock_step();
        checks++;
        if (link_out_valid !== 1'b0 || link_out_flit !== 16'h5923) begin
            failures++;
            $display("FAIL inject_hold: got v=%b flit=%h required v=0 flit=5923", link_out_valid, link_out_flit);
        end
    endtask

    task automatic test_credit_stall();
        int pushes = 0;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            gpu_tx_valid = (pushes < 6);
            gpu_tx_data  = 16'($urandom);
            if (gpu_tx_valid && gpu_tx_ready) pushes++;
            clock_step();
            if (link_out_valid === 1'b1) pulses++;
            checks++;
            if (link_out_valid !== m_out_valid || link_out_flit !== m_out_flit ||
                gpu_tx_ready !== (m_tx_q.size() < TX_DEPTH)) begin
                failures++;
                $display("FAIL stall_cycle%0d: got v=%b flit=%h rdy=%b required v=%b flit=%h rdy=%b", i,
                         link_out_valid, link_out_flit, gpu_tx_ready, m_out_valid, m_out_flit,
                         m_tx_q.size() < TX_DEPTH);
            end
        end
        gpu_tx_valid = 1'b0;
        checks++;
        if (pulses !== CREDITS) begin
            failures++;
            $display("FAIL stall_pulses: got %0d required %0d", pulses, CREDITS);
        end
        link_out_credit = 1'b1;
        clock_step();
        link_out_credit = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            clock_step();
            if (link_out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1 || tx_count !== 16'd5) begin
            failures++;
            $display("FAIL stall_refill: got pulses=%0d cnt=%0d required pulses=1 cnt=5", pulses, tx_count);
        end
    endtask

    task automatic test_rx_deliver();
        do_reset();
        gpu_rx_ready  = 1'b1;
        link_in_flit  = 16'h5523;
        link_in_valid = 1'b1;
        clock_step();
        link_in_valid = 1'b0;
        checks++;
        if (gpu_rx_valid !== 1'b1 || gpu_rx_data !== 16'h5523 || link_in_credit !== 2'd0) begin
            failures++;
            $display("FAIL rx_arrive: got v=%b data=%h cr=%0d required v=1 data=5523 cr=0",
                     gpu_rx_valid, gpu_rx_data, link_in_credit);
        end
        clock_step();
        checks++;
        if (gpu_rx_valid !== 1'b0 || link_in_credit !== 2'd1 || rx_count !== 16'd1) begin
            failures++;
            $display("FAIL rx_popped: got v=%b cr=%0d cnt=%0d required v=0 cr=1 cnt=1",
                     gpu_rx_valid, link_in_credit, rx_count);
        end
        clock_step();
        checks++;
        if (link_in_credit !== 2'd0) begin
            failures++;
            $display("FAIL rx_credit_once: got %0d required 0", link_in_credit);
        end
    endtask

    task automatic test_drop_with_pop();
        do_reset();
        link_in_flit  = {NODE_ID, 10'($urandom)};
        link_in_valid = 1'b1;
        clock_step();
        gpu_rx_ready  = 1'b1;
        link_in_flit  = 16'h0C01;
        clock_step();
        link_in_valid = 1'b0;
        checks++;
        if (drop_count !== 16'd1 || link_in_credit !== 2'd2 || rx_count !== 16'd1) begin
            failures++;
            $display("FAIL drop_pop: got drop=%0d cr=%0d rx=%0d required drop=1 cr=2 rx=1",
                     drop_count, link_in_credit, rx_count);
        end
        clock_step();
        checks++;
        if (link_in_credit !== 2'd0) begin
            failures++;
            $display("FAIL drop_pop_after: got %0d required 0", link_in_credit);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_q[$];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            link_in_flit  = {NODE_ID, 10'($urandom)};
            link_in_valid = 1'b1;
            if (i < RX_DEPTH) exp_q.push_back(link_in_flit);
            clock_step();
        end
        link_in_valid = 1'b0;
        checks++;
        if (rx_ovf_err !== 1'b1 || drop_count !== 16'd1 || link_in_credit !== 2'd1 || credit_err !== 1'b0) begin
            failures++;
            $display("FAIL overflow: got ovf=%b drop=%0d cr=%0d cerr=%b required ovf=1 drop=1 cr=1 cerr=0",
                     rx_ovf_err, drop_count, link_in_credit, credit_err);
        end
        link_out_credit = 1'b1;
        clock_step();
        link_out_credit = 1'b0;
        checks++;
        if (credit_err !== 1'b1) begin
            failures++;
            $display("FAIL credit_err: got %b required 1", credit_err);
        end
        gpu_rx_ready = 1'b1;
        for (int i = 0; i < RX_DEPTH; i++) begin
            checks++;
            if (gpu_rx_valid !== 1'b1 || gpu_rx_data !== exp_q[i]) begin
                failures++;
                $display("FAIL drain%0d: got v=%b data=%h required v=1 data=%h", i, gpu_rx_valid, gpu_rx_data, exp_q[i]);
            end
            clock_step();
        end
        checks++;
        if (gpu_rx_valid !== 1'b0 || rx_count !== 16'd4) begin
            failures++;
            $display("FAIL drain_done: got v=%b cnt=%0d required v=0 cnt=4", gpu_rx_valid, rx_count);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            gpu_tx_valid  = 1'b1;
            gpu_tx_data   = 16'($urandom);
            link_in_valid = (i < 2);
            link_in_flit  = {NODE_ID, 10'($urandom)};
            clock_step();
        end
        idle_inputs();
        checks++;
        if (gpu_rx_valid !== 1'b1 || tx_count !== 16'd4) begin
            failures++;
            $display("FAIL mid_prefill: got rx_v=%b tx_cnt=%0d required rx_v=1 tx_cnt=4", gpu_rx_valid, tx_count);
        end
        #2;
        ARESET = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({gpu_tx_ready, gpu_rx_data, gpu_rx_valid, link_out_flit, link_out_valid, link_in_credit,
             tx_count, rx_count, drop_count, credit_err, rx_ovf_err} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got tx_rdy=%b rx_v=%b out_v=%b cnts=%h/%h/%h required all 0",
                     gpu_tx_ready, gpu_rx_valid, link_out_valid, tx_count, rx_count, drop_count);
        end
        clock_step();
        ARESET = 1'b0;
        clock_step();
        checks++;
        if (gpu_rx_valid !== 1'b0 || link_out_valid !== 1'b0 || tx_count !== 16'd0 || gpu_tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_release: got rx_v=%b out_v=%b tx_cnt=%0d rdy=%b required 0 0 0 1",
                     gpu_rx_valid, link_out_valid, tx_count, gpu_tx_ready);
        end
        for (int i = 0; i < 7; i++) begin
            gpu_tx_valid = (i < 5);
            gpu_tx_data  = 16'($urandom);
            clock_step();
            if (link_out_valid === 1'b1) pulses++;
        end
        gpu_tx_valid = 1'b0;
        checks++;
        if (pulses !== CREDITS) begin
            failures++;
            $display("FAIL mid_credit_reload: got %0d pulses required %0d", pulses, CREDITS);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            gpu_tx_valid    = ($urandom_range(0, 99) < 60);
            gpu_tx_data     = 16'($urandom);
            gpu_rx_ready    = ($urandom_range(0, 99) < 70);
            link_in_valid   = ($urandom_range(0, 99) < 50);
            link_in_flit    = ($urandom_range(0, 99) < 75) ? {NODE_ID, 10'($urandom)} : 16'($urandom);
            link_out_credit = ((m_credits < CREDITS) && ($urandom_range(0, 99) < 40)) ||
                              ($urandom_range(0, 99) < 2);
            clock_step();
            checks++;
            if (link_out_valid !== m_out_valid || link_out_flit !== m_out_flit ||
                gpu_tx_ready !== (m_tx_q.size() < TX_DEPTH)) begin
                failures++;
                $display("FAIL rand_tx%0d: got v=%b flit=%h rdy=%b required v=%b flit=%h rdy=%b", i,
                         link_out_valid, link_out_flit, gpu_tx_ready, m_out_valid, m_out_flit, m_tx_q.size() < TX_DEPTH);
            end
            checks++;
            if (gpu_rx_valid !== (m_rx_q.size() > 0) ||
                (m_rx_q.size() > 0 && gpu_rx_data !== m_rx_q[0]) || link_in_credit !== 2'(m_in_credit)) begin
                failures++;
                $display("FAIL rand_rx%0d: got v=%b data=%h cr=%0d required v=%b cr=%0d", i,
                         gpu_rx_valid, gpu_rx_data, link_in_credit, m_rx_q.size() > 0, m_in_credit);
            end
            checks++;
            if (tx_count !== 16'(m_tx_cnt) || rx_count !== 16'(m_rx_cnt) || drop_count !== 16'(m_drop_cnt) ||
                credit_err !== m_cerr || rx_ovf_err !== m_oerr) begin
                failures++;
                $display("FAIL rand_stats%0d: got %0d/%0d/%0d cerr=%b ovf=%b required %0d/%0d/%0d cerr=%b ovf=%b", i,
                         tx_count, rx_count, drop_count, credit_err, rx_ovf_err,
                         m_tx_cnt, m_rx_cnt, m_drop_cnt, m_cerr, m_oerr);
            end
        end
        idle_inputs();
    endtask

    initial begin
        ARESET = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_inject();
        test_credit_stall();
        test_rx_deliver();
        test_drop_with_pop();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
